firmware_memory_arbiter: RTL and testbench
==========================================

# firmware_memory_arbiter

Two-master arbiter that shares the single-port 32-bit firmware on-chip memory (51200 words, 1-cycle read latency) between the Nios data master (m0) and a second requester such as a DMA or loader (m1). It accepts Avalon-MM single-beat reads and writes, grants at most one access per cycle, and returns read data with `readdatavalid` to the owning master. It supports grant locking with a hold limit, and it flags out-of-range addresses. The block sits between the system interconnect and the memory's s1 port.

## Interface
- `DEPTH`, 51200: number of implemented 32-bit words. A word address `>= DEPTH` is out of range.
- `MAX_HOLD`, 8: maximum consecutive accesses a locked master keeps the grant while the other master waits. Range 1..255.
- `clk` in 1: single clock. All state changes on its rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `mN_address` (N=0,1) in 16: word address.
- `mN_read` / `mN_write` in 1: request strobes. If both are high, the access is a write and the read is ignored.
- `mN_byteenable` in 4: byte lanes for writes.
- `mN_writedata` in 32: write data.
- `mN_lock` in 1: request to keep the grant for the following access.
- `mN_waitrequest` out 1: stall. The access is accepted on a cycle where the request is high and `waitrequest` is low.
- `mN_readdata` out 32: read data. Valid only when `mN_readdatavalid` is high.
- `mN_readdatavalid` out 1: one-cycle read return.
- `mem_address` out 16, `mem_byteenable` out 4, `mem_writedata` out 32, `mem_write` out 1, `mem_chipselect` out 1: memory port, driven by the granted master.
- `mem_clken` out 1: tied to 1 outside reset, 0 while `reset_n` is low.
- `mem_readdata` in 32: unregistered memory output.
- `err_oor` out 1: sticky out-of-range flag.
- `err_clr` in 1: clears `err_oor`.

## Operation
Arbitration is combinational each cycle from the requests and three registers: `last` (1 bit), `hold_cnt` (8 bits) and `locked` (1 bit).

**Lock override**
- Applies when `locked` is set, the same master requests again, and `hold_cnt < MAX_HOLD`, or when the other master is idle.
- In that case the locked master keeps the grant.

**Normal arbitration**
- With `FW_ARB_RR_EN` defined: a single requester is granted. With two requesters, the master other than `last` is granted.
- Without `FW_ARB_RR_EN`: see Configuration.

**On every grant (rising edge)**
- `last` becomes the granted master.
- `locked` becomes the granted master's `mN_lock`.
- `hold_cnt` increments (saturating at 255) if the grant repeats the previous master, otherwise it loads 1.
- A cycle with no grant clears `locked` and `hold_cnt`.

**Memory port and waitrequest**
- The memory port is a mux of the granted master's signals.
- `mem_chipselect` = grant is valid and address is in range.
- `mem_write` = the granted access is a write.
- `mN_waitrequest` = `mN` is requesting and is not granted. It is also 1 for any request during reset.

**Read return pipeline**
- One register stage holds `rd_pend`, `rd_owner` and `rd_oor`.
- In cycle N+1, `m{rd_owner}_readdatavalid` = 1.
- `m{rd_owner}_readdata` = `mem_readdata`, or 32'h0000_0000 if `rd_oor`.
- The non-owner sees `readdatavalid` 0 and `readdata` 0.

**Out-of-range accesses**
- They are accepted (no stall) and never reach memory; the write is dropped.
- A read returns zero.
- `err_oor` sets at N+1.
- If `err_clr` and a new set event occur in the same cycle, the set wins.

**Reset values**
- `last` = 1, so m0 wins the first contention.
- `locked`, `hold_cnt`, `rd_pend` and `err_oor` all 0.
- All `readdatavalid` outputs 0; `mem_chipselect` 0.

## Timing
- Grant, `waitrequest` and the memory port are combinational in the request cycle N. No added latency for an uncontended access.
- Read data is returned in cycle N+1. Latency is fixed at 1, and back-to-back reads return on consecutive cycles.
- Throughput is one access per cycle, shared between the two masters.
- Worst-case wait for a master:
  - `MAX_HOLD` cycles while the other master is locked.
  - 1 cycle otherwise, with round-robin enabled.
- Reset asserted mid-read: the pending `readdatavalid` is suppressed, and the master must reissue the read.
- `reset_n` high in cycle R: the first grant is possible in cycle R.

## Configuration
- `FW_ARB_RR_EN` defined: round-robin between m0 and m1, with the lock and `MAX_HOLD` rules above.
- `FW_ARB_RR_EN` undefined: fixed priority, m0 over m1.
  - Locks are still honoured and `MAX_HOLD` still bounds m0's lock.
  - An unlocked m0 requesting every cycle starves m1 indefinitely.

## Test plan
- **Single write then read:** m0 writes 0xCAFEF00D to address 0x0010 with `byteenable` 4'hF, then reads 0x0010. Required: no wait on either access; `m0_readdatavalid` high in the cycle after the read with `m0_readdata` = 0xCAFEF00D; `m1_readdatavalid` stays 0.
- **Contention, round-robin (`FW_ARB_RR_EN` defined):** m0 and m1 both read continuously from reset. Required: grants m0, m1, m0, m1…; each master sees `waitrequest` high in alternate cycles; data returns to the correct owner.
- **Lock with hold limit, `MAX_HOLD`=3:** m1 reads with `m1_lock`=1 while m0 requests continuously. Required: m1 is granted 3 consecutive accesses, then m0 is granted; m0 waits exactly 3 cycles.
- **Out of range:** m1 writes 0x12345678 to address 51200, then reads 51200. Required: `mem_chipselect` 0 both cycles; the read returns 0x00000000 with `readdatavalid` 1; `err_oor` is 1 from the next cycle; `err_clr` clears it; with `err_clr` and a new out-of-range access in the same cycle, `err_oor` stays 1.
- **Reset mid-read and fixed priority:** assert `reset_n`=0 in the cycle after an m0 read is accepted. Required: no `readdatavalid`; all outputs at their reset values. With `FW_ARB_RR_EN` undefined and both masters requesting continuously, m0 is always granted and m1's `waitrequest` stays 1.

Source files
------------

// File: rtl/firmware_memory_arbiter.sv
// firmware_memory_arbiter: shares the single-port firmware RAM between m0 (Nios data) and m1 (DMA/loader).
// Define FW_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority over m1.
module firmware_memory_arbiter #(
  parameter int DEPTH    = 51200,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byteenable,
  input  logic [31:0] m0_writedata,
  input  logic        m0_lock,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [15:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byteenable,
  input  logic [31:0] m1_writedata,
  input  logic        m1_lock,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [15:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  output logic        mem_write,
  output logic        mem_chipselect,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,
  output logic        err_oor,
  input  logic        err_clr
);
  localparam logic [7:0]  MAX_H = 8'(MAX_HOLD);
  localparam logic [16:0] LIMIT = 17'(DEPTH);
  logic       last, locked, rd_pend, rd_owner, rd_oor;
  logic [7:0] hold_cnt;
  logic       req0, req1, other_req, keep, expired, pick, sel, gv, wr_g, oor_g, rv;
  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign other_req = last ? req0 : req1;
  assign keep      = locked && (last ? req1 : req0) && (hold_cnt < MAX_H || !other_req);
  // a locked master past its hold limit yields to the waiting master in either mode
  assign expired   = locked && req0 && req1 && hold_cnt >= MAX_H;
`ifdef FW_ARB_RR_EN
  assign pick = (req0 && req1) ? ~last : req1;
`else
  assign pick = ~req0;
`endif
  assign sel   = keep ? last : expired ? ~last : pick;
  assign gv    = reset_n && (req0 || req1);
  assign wr_g  = sel ? m1_write : m0_write;
  assign mem_address    = sel ? m1_address : m0_address;
  assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = sel ? m1_writedata : m0_writedata;
  assign oor_g          = {1'b0, mem_address} >= LIMIT;
  assign mem_chipselect = gv && !oor_g;
  assign mem_write      = gv && wr_g;
  assign mem_clken      = reset_n;
  assign m0_waitrequest = req0 && !(gv && !sel);
  assign m1_waitrequest = req1 && !(gv && sel);
  assign rv               = reset_n && rd_pend;
  assign m0_readdatavalid = rv && !rd_owner;
  assign m1_readdatavalid = rv && rd_owner;
  assign m0_readdata      = (m0_readdatavalid && !rd_oor) ? mem_readdata : 32'h0;
  assign m1_readdata      = (m1_readdatavalid && !rd_oor) ? mem_readdata : 32'h0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last     <= 1'b1;
      locked   <= 1'b0;
      hold_cnt <= 8'd0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      rd_oor   <= 1'b0;
      err_oor  <= 1'b0;
    end else begin
      rd_pend  <= gv && !wr_g;
      rd_owner <= sel;
      rd_oor   <= oor_g;
      err_oor  <= (gv && oor_g) || (err_oor && !err_clr);
      if (gv) begin
        last     <= sel;
        locked   <= sel ? m1_lock : m0_lock;
        hold_cnt <= (sel != last) ? 8'd1 : (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
      end else begin
        locked   <= 1'b0;
        hold_cnt <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_firmware_memory_arbiter.sv
// tb_firmware_memory_arbiter: directed plus random traffic checked against a behavioural arbiter/memory model.
module tb_firmware_memory_arbiter;
  localparam int HOLD = 3;
  localparam int DEP  = 51200;
`ifdef FW_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 0, m0_write = 0, m0_lock = 0, m1_read = 0, m1_write = 0, m1_lock = 0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, mem_writedata, mem_q;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_write, mem_chipselect, mem_clken, err_oor, err_clr = 0;
  int vectors = 0, miscompares = 0;
  firmware_memory_arbiter #(.DEPTH(DEP), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .reset_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_byteenable(m0_byteenable),
    .m0_writedata(m0_writedata), .m0_lock(m0_lock), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_byteenable(m1_byteenable),
    .m1_writedata(m1_writedata), .m1_lock(m1_lock), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_write(mem_write), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_readdata(mem_q), .err_oor(err_oor), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  bit [31:0] ram [0:DEP-1];
  always @(posedge clk)
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[int'(mem_address)][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else mem_q <= ram[int'(mem_address)];
    end
  bit [31:0] ref_mem [0:DEP-1];
  int        m_last = 1, m_hold = 0, p_owner = 0, s_g = 0;
  bit        m_locked = 0, p_valid = 0, m_err = 0, s_w0, s_w1, s_gv;
  logic [31:0] p_data = '0, s_rd0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock, err_clr} = '0;
  endtask
  // one clock: check outputs mid-cycle against the model, then advance the model at the edge
  task automatic cyc();
    bit r0, r1, gv, w, oor, lk, clr;
    int g;
    logic [15:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    @(negedge clk);
    r0 = m0_read || m0_write;
    r1 = m1_read || m1_write;
    gv = rst_n && (r0 || r1);
    if (r0 && r1) g = (m_locked && m_hold < HOLD) ? m_last : (m_locked || RR) ? 1 - m_last : 0;
    else g = r1 ? 1 : 0;
    a   = g ? m1_address : m0_address;
    w   = g ? m1_write : m0_write;
    wd  = g ? m1_writedata : m0_writedata;
    be  = g ? m1_byteenable : m0_byteenable;
    lk  = g ? m1_lock : m0_lock;
    clr = err_clr;
    oor = int'(a) >= DEP;
    chk("wait0", m0_waitrequest, r0 && !(gv && g == 0));
    chk("wait1", m1_waitrequest, r1 && !(gv && g == 1));
    chk("chipselect", mem_chipselect, gv && !oor);
    chk("mem_write", mem_write, gv && w);
    if (gv) chk("mem_address", mem_address, a);
    if (gv && w) chk("mem_writedata", mem_writedata, wd);
    if (gv && w) chk("mem_byteenable", mem_byteenable, be);
    chk("rdv0", m0_readdatavalid, rst_n && p_valid && p_owner == 0);
    chk("rdv1", m1_readdatavalid, rst_n && p_valid && p_owner == 1);
    chk("rdata0", m0_readdata, (rst_n && p_valid && p_owner == 0) ? p_data : 32'h0);
    chk("rdata1", m1_readdata, (rst_n && p_valid && p_owner == 1) ? p_data : 32'h0);
    chk("err_oor", err_oor, m_err);
    chk("clken", mem_clken, rst_n);
    s_w0 = m0_waitrequest; s_w1 = m1_waitrequest; s_gv = gv; s_g = g; s_rd0 = m0_readdata;
    @(posedge clk);
    if (!rst_n) begin
      m_last = 1; m_locked = 0; m_hold = 0; p_valid = 0; m_err = 0;
    end else begin
      p_valid = gv && !w;
      p_owner = g;
      p_data  = oor ? 32'h0 : ref_mem[int'(a)];
      m_err   = (gv && oor) || (m_err && !clr);
      if (gv) begin
        m_hold   = (g == m_last) ? (m_hold == 255 ? 255 : m_hold + 1) : 1;
        m_last   = g;
        m_locked = lk;
        if (w && !oor)
          for (int b = 0; b < 4; b++) if (be[b]) ref_mem[int'(a)][8*b +: 8] = wd[8*b +: 8];
      end else begin
        m_locked = 0; m_hold = 0;
      end
    end
    #1;
  endtask
  initial begin
    int waits, g0;
    #1;
    m0_read = 1; m1_read = 1;
    repeat (3) cyc();
    idle(); rst_n = 1;
    cyc();
    m0_write = 1; m0_address = 16'h0010; m0_writedata = 32'hCAFEF00D; m0_byteenable = 4'hF;
    cyc();
    idle(); m0_read = 1;
    cyc();
    idle();
    cyc();
    chk("cafe_read", s_rd0, 32'hCAFEF00D);
    m0_read = 1; m1_read = 1; g0 = 0;
    for (int i = 0; i < 8; i++) begin
      m0_address = 16'(i); m1_address = 16'(i + 8);
      cyc();
      if (s_gv && s_g == 0) g0++;
    end
    chk("contention_m0_grants", g0, RR ? 4 : 8);
    idle(); cyc();
    m0_read = 1; cyc();
    m1_read = 1; m1_lock = 1; waits = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!s_w0) break;
      waits++;
    end
    chk("lock_m0_waits", waits, RR ? HOLD : 0);
    idle(); cyc();
    m1_write = 1; m1_address = 16'(DEP); m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
    cyc();
    idle(); m1_read = 1; cyc();
    idle(); cyc();
    err_clr = 1; cyc();
    m1_read = 1; cyc();
    idle(); cyc();
    chk("err_clr_vs_set", err_oor, 1'b1);
    m0_read = 1; m0_address = 16'h0010; cyc();
    idle(); rst_n = 0; cyc();
    cyc();
    rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 63) != 0);
      m0_read    = $urandom_range(0, 1); m0_write = ($urandom_range(0, 3) == 0);
      m1_read    = $urandom_range(0, 1); m1_write = ($urandom_range(0, 3) == 0);
      m0_lock    = ($urandom_range(0, 2) == 0); m1_lock = ($urandom_range(0, 2) == 0);
      m0_address = ($urandom_range(0, 15) == 0) ? 16'(DEP + $urandom_range(0, 200)) : 16'($urandom_range(0, 31));
      m1_address = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
      m0_writedata = $urandom; m1_writedata = $urandom;
      m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
      err_clr    = ($urandom_range(0, 7) == 0);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
